// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: sequential fetch PC generator with one outstanding I-cache request,
// redirect/kill handling, and a small instruction FIFO feeding decode.
module ifu_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        icache_req_valid_o,
  input  logic        icache_req_ready_i,
  output logic [31:0] icache_req_addr_o,
  input  logic        icache_resp_valid_i,
  output logic        icache_resp_ready_o,
  input  logic [31:0] icache_resp_data_i,
  input  logic [31:0] icache_resp_addr_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, KILL} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mem_pc_q [FQ_DEPTH];
  logic [31:0] mem_data_q [FQ_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic req_hs, resp_hs, push, pop;
  logic [31:0] redir_pc;
  assign redir_pc = redirect_pc_i & ~32'h3;
  assign icache_req_valid_o = (state_q == REQ) && (count_q < CW'(FQ_DEPTH));
  assign icache_req_addr_o = pc_q;
  assign icache_resp_ready_o = (state_q == WAIT) || (state_q == KILL);
  assign req_hs = icache_req_valid_o & icache_req_ready_i;
  assign resp_hs = icache_resp_ready_o & icache_resp_valid_i;
  // Only a non-redirected WAIT response for the current PC is kept; KILL always drops.
  assign push = (state_q == WAIT) && resp_hs && !redirect_valid_i && (icache_resp_addr_i == pc_q);
  assign inst_valid_o = count_q != '0;
  assign pop = inst_valid_o & inst_ready_i;
  assign inst_o = inst_valid_o ? mem_data_q[rptr_q] : '0;
  assign inst_pc_o = inst_valid_o ? mem_pc_q[rptr_q] : '0;
  always_comb begin
    state_d = state_q;
    pc_d = redirect_valid_i ? redir_pc : push ? pc_q + 32'd4 : pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: state_d = req_hs ? (redirect_valid_i ? KILL : WAIT) : REQ;
      WAIT: state_d = resp_hs ? REQ : (redirect_valid_i ? KILL : WAIT);
      KILL: state_d = resp_hs ? REQ : KILL;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn || redirect_valid_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      mem_pc_q[wptr_q] <= pc_q;
      mem_data_q[wptr_q] <= icache_resp_data_i;
    end
  end
endmodule
